// File: rtl/mult_pipe_pkg.sv
// Shared constants and level-scheduling helpers for the pipelined multiplier.
package mult_pipe_pkg;

    localparam int unsigned MP_WIDTH  = 32;
    localparam int unsigned MP_STAGES = 3;
    localparam int unsigned MP_TAG_W  = 5;

    // Adder-tree levels evaluated in stage k; earlier stages take the remainder.
    function automatic int unsigned levels_in_stage(input int unsigned k,
                                                    input int unsigned levels,
                                                    input int unsigned stages);
        return (levels / stages) + ((k < (levels % stages)) ? 1 : 0);
    endfunction

    // Number of tree levels completed once stage k has been evaluated.
    function automatic int unsigned stage_end(input int unsigned k,
                                              input int unsigned levels,
                                              input int unsigned stages);
        int unsigned acc;
        acc = 0;
        for (int unsigned j = 0; j <= k; j++) begin
            acc += levels_in_stage(j, levels, stages);
        end
        return acc;
    endfunction

    // Non-final stage whose register sits at level boundary lvl, or stages if none.
    function automatic int unsigned boundary_stage(input int unsigned lvl,
                                                   input int unsigned levels,
                                                   input int unsigned stages);
        for (int unsigned k = 0; k + 1 < stages; k++) begin
            if (stage_end(k, levels, stages) == lvl) begin
                return k;
            end
        end
        return stages;
    endfunction

    // Node width at tree level lvl: leaves are width+1, each level adds 1 + shift.
    function automatic int unsigned node_w(input int unsigned width,
                                           input int unsigned lvl);
        return width + lvl + (32'd1 << lvl);
    endfunction

endpackage

// File: rtl/mult_tree_level.sv
// One adder-tree level: sums adjacent node pairs, the odd node weighted by 2^SHIFT.
module mult_tree_level
    import mult_pipe_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned IN_W  = 9,
    parameter int unsigned SHIFT = 1
) (
    input  logic [N_IN*IN_W-1:0]                  in_i,
    output logic [(N_IN/2)*(IN_W+1+SHIFT)-1:0]    out_o
);

    localparam int unsigned N_OUT = N_IN / 2;
    localparam int unsigned OUT_W = IN_W + 1 + SHIFT;

    for (genvar j = 0; j < N_OUT; j++) begin : pair_g
        logic [IN_W-1:0] lo_w;
        logic [IN_W-1:0] hi_w;
        logic [IN_W:0]   sum_w;

        // Low SHIFT bits of the even node pass through; the rest is added to the odd node.
        always_comb begin
            lo_w  = in_i[(2*j)*IN_W +: IN_W];
            hi_w  = in_i[(2*j+1)*IN_W +: IN_W];
            sum_w = {1'b0, hi_w} + {{(SHIFT+1){1'b0}}, lo_w[IN_W-1:SHIFT]};
            out_o[j*OUT_W +: OUT_W] = {sum_w, lo_w[SHIFT-1:0]};
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake, tag sideband and flush.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = MP_WIDTH,
    parameter int unsigned STAGES = MP_STAGES,
    parameter int unsigned TAG_W  = MP_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_opr1,
    input  logic [WIDTH-1:0]   in_opr2,
    input  logic               in_unsigned,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned LW     = WIDTH + 1;
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned FW     = node_w(WIDTH, LEVELS);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] neg_q;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_neg;
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic              accept;
    logic              neg_in;
    logic [LW-1:0]     mag1;
    logic [LW-1:0]     mag2;
    logic [WIDTH*LW-1:0] leaves;
    logic [FW-1:0]     mag_fin;
    logic [PW-1:0]     prod_d;
    logic [PW-1:0]     prod_q;
    logic              unused_bits;

    // Backward ready chain: a stage loads when empty or when its successor can take it.
    always_comb begin
        ld = '0;
        ld[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int unsigned i = 1; i < STAGES; i++) begin
            ld[STAGES-1-i] = !v_q[STAGES-1-i] || ld[STAGES-i];
        end
        in_ready = ld[0] && !flush && !reset;
        accept   = in_valid && in_ready;
    end

    // Operand magnitudes (WIDTH+1 bits so the most negative value is exact) and partial products.
    always_comb begin
        mag1 = {1'b0, in_opr1};
        mag2 = {1'b0, in_opr2};
        if (!in_unsigned && in_opr1[WIDTH-1]) mag1 = -{1'b1, in_opr1};
        if (!in_unsigned && in_opr2[WIDTH-1]) mag2 = -{1'b1, in_opr2};
        neg_in = !in_unsigned && (in_opr1[WIDTH-1] ^ in_opr2[WIDTH-1]);
        leaves = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            leaves[i*LW +: LW] = mag1 & {LW{mag2[i]}};
        end
    end

    // Per-stage sources: stage 0 takes the new operation, stage k the content of stage k-1.
    always_comb begin
        src_v      = '0;
        src_neg    = '0;
        src_v[0]   = accept;
        src_neg[0] = neg_in;
        src_tag[0] = in_tag;
        for (int unsigned i = 1; i < STAGES; i++) begin
            src_v[i]   = v_q[i-1];
            src_neg[i] = neg_q[i-1];
            src_tag[i] = tag_q[i-1];
        end
    end

    // Tree levels; a pipeline register is inserted at each non-final stage boundary.
    for (genvar l = 0; l <= LEVELS; l++) begin : nd_g
        localparam int unsigned N  = WIDTH >> l;
        localparam int unsigned IW = node_w(WIDTH, l);
        localparam int unsigned BS = boundary_stage(l, LEVELS, STAGES);
        logic [N*IW-1:0] node;

        if (l == 0) begin : src_g
            assign node = leaves;
        end else if (BS < STAGES) begin : reg_g
            logic [N*IW-1:0] node_q;
            // Capture the partially reduced tree at the end of stage BS.
            always_ff @(posedge clk) begin
                if (ld[BS] && src_v[BS]) node_q <= nd_g[l-1].lv_g.y;
            end
            assign node = node_q;
        end else begin : thru_g
            assign node = nd_g[l-1].lv_g.y;
        end

        if (l < LEVELS) begin : lv_g
            localparam int unsigned OW = node_w(WIDTH, l + 1);
            logic [(N/2)*OW-1:0] y;
            mult_tree_level #(
                .N_IN (N),
                .IN_W (IW),
                .SHIFT(32'd1 << l)
            ) u_level (
                .in_i (node),
                .out_o(y)
            );
        end
    end

    // Sign fix-up in the last stage: negate the magnitude product when operand signs differ.
    always_comb begin
        mag_fin     = nd_g[LEVELS].node;
        prod_d      = src_neg[STAGES-1] ? -mag_fin[PW-1:0] : mag_fin[PW-1:0];
        unused_bits = ^{mag_fin[FW-1:PW], mag2[WIDTH], neg_q[STAGES-1]};
    end

    // Stage registers; sideband loads only with a valid source, flush/reset drop all valids.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (ld[i]) v_q[i] <= src_v[i];
            if (ld[i] && src_v[i]) begin
                neg_q[i] <= src_neg[i];
                tag_q[i] <= src_tag[i];
            end
        end
        if (ld[STAGES-1] && src_v[STAGES-1]) prod_q <= prod_d;
        if (reset || flush) v_q <= '0;
        if (reset) begin
            prod_q           <= '0;
            tag_q[STAGES-1]  <= '0;
        end
    end

    assign out_valid  = v_q[STAGES-1];
    assign out_result = prod_q;
    assign out_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_mult_pipe.sv
// Randomized and directed bench for mult_pipe against a queue-based reference model.
module tb_mult_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 3;
    localparam int unsigned TW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_opr1;
    logic [W-1:0]    in_opr2;
    logic            in_unsigned;
    logic [TW-1:0]   in_tag;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_result;
    logic [TW-1:0]   out_tag;

    always #5 clk = ~clk;

    mult_pipe #(
        .WIDTH (W),
        .STAGES(S),
        .TAG_W (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opr1    (in_opr1),
        .in_opr2    (in_opr2),
        .in_unsigned(in_unsigned),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    typedef struct {
        logic [63:0]   res;
        logic [TW-1:0] tag;
        int unsigned   acc;
    } op_t;

    op_t         q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned ncyc     = 0;
    bit          rst_zero = 1'b0;
    logic        obs_ov;
    logic        obs_rdy;
    logic        obs_acc;
    logic [63:0] obs_res;
    logic [TW-1:0] obs_tag;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic uns);
        longint      sa;
        longint      sb;
        logic [63:0] r;
        if (uns) begin
            r = {32'b0, a} * {32'b0, b};
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            r  = sa * sb;
        end
        return r;
    endfunction

    // One clock cycle: inputs already driven after the falling edge; sample 1 ns before the rising edge.
    task automatic cycle();
        bit  exp_ready;
        bit  exp_ov;
        op_t op;
        #4;
        exp_ready = !reset && !flush && ((q.size() < S) || out_ready);
        exp_ov    = (q.size() > 0) && (ncyc >= q[0].acc + S - 1);
        check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
        check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            check_eq("out_result", out_result, q[0].res);
            check_eq("out_tag", 64'(out_tag), 64'(q[0].tag));
            rst_zero = 1'b0;
        end else if (rst_zero) begin
            check_eq("reset_result", out_result, 64'd0);
            check_eq("reset_tag", 64'(out_tag), 64'd0);
        end
        obs_ov  = out_valid;
        obs_rdy = in_ready;
        obs_acc = in_valid && in_ready;
        obs_res = out_result;
        obs_tag = out_tag;
        if (reset) begin
            q.delete();
            rst_zero = 1'b1;
        end else if (flush) begin
            q.delete();
            rst_zero = 1'b0;
        end else begin
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                op.res = ref_mul(in_opr1, in_opr2, in_unsigned);
                op.tag = in_tag;
                op.acc = ncyc + 1;
                q.push_back(op);
            end
        end
        @(posedge clk);
        ncyc++;
        @(negedge clk);
    endtask

    task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic u, input logic [TW-1:0] t, input logic [63:0] exp);
        int unsigned lat;
        lat         = 0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_opr1     = a;
        in_opr2     = b;
        in_unsigned = u;
        in_tag      = t;
        cycle();
        check_eq({nm, "_accept"}, 64'(obs_acc), 64'd1);
        in_valid = 1'b0;
        for (int unsigned i = 1; i <= 10; i++) begin
            cycle();
            if (obs_ov) begin
                lat = i;
                break;
            end
        end
        check_eq({nm, "_latency"}, 64'(lat), 64'(S));
        check_eq({nm, "_result"}, obs_res, exp);
        check_eq({nm, "_tag"}, 64'(obs_tag), 64'(t));
    endtask

    logic [31:0] corner [5];
    logic [31:0] sa_op  [8];
    logic [31:0] sb_op  [8];

    initial begin
        int unsigned idx;
        int unsigned drained;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;

        reset = 1'b1; in_valid = 1'b0; in_opr1 = '0; in_opr2 = '0;
        in_unsigned = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_zero = 1'b1;

        // Reset held: in_ready low, outputs cleared; first cycle after release accepts.
        cycle();
        check_eq("ready_in_reset", 64'(obs_rdy), 64'd0);
        reset = 1'b0;
        cycle();
        check_eq("ready_after_reset", 64'(obs_rdy), 64'd1);
        check_eq("ov_after_reset", 64'(obs_ov), 64'd0);

        single("neg7x6", 32'hFFFF_FFF9, 32'd6, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFD6);
        single("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd17, 64'hFFFF_FFFE_0000_0001);
        single("smin", 32'h8000_0000, 32'h8000_0000, 1'b0, 5'd30, 64'h4000_0000_0000_0000);

        // Streaming into a stalled consumer, then drain.
        for (int unsigned i = 0; i < 8; i++) begin
            sa_op[i] = $urandom;
            sb_op[i] = $urandom;
        end
        idx = 0;
        drained = 0;
        out_ready = 1'b0;
        for (int unsigned c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_opr1 = sa_op[idx]; in_opr2 = sb_op[idx];
            in_unsigned = 1'b0; in_tag = TW'(idx);
            cycle();
            if (obs_ov) check_eq("stall_hold", obs_res, ref_mul(sa_op[0], sb_op[0], 1'b0));
            if (obs_acc) idx++;
        end
        check_eq("stall_accepts", 64'(idx), 64'(S));
        out_ready = 1'b1;
        for (int unsigned c = 0; c < 60 && (idx < 8 || q.size() > 0); c++) begin
            in_valid = (idx < 8); in_opr1 = sa_op[idx % 8]; in_opr2 = sb_op[idx % 8];
            in_tag = TW'(idx);
            cycle();
            if (obs_acc) idx++;
            if (obs_ov) drained++;
        end
        in_valid = 1'b0;
        check_eq("stream_drained", 64'(drained), 64'd8);

        // Flush with a full pipeline; the pair presented with flush is refused.
        out_ready = 1'b0;
        idx = 0;
        for (int unsigned c = 0; c < 10 && idx < 3; c++) begin
            in_valid = 1'b1; in_opr1 = $urandom; in_opr2 = $urandom; in_tag = TW'(20 + idx);
            cycle();
            if (obs_acc) idx++;
        end
        check_eq("flush_fill", 64'(idx), 64'd3);
        flush = 1'b1;
        cycle();
        check_eq("flush_refuse", 64'(obs_acc), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        cycle();
        check_eq("flush_ov", 64'(obs_ov), 64'd0);
        single("after_flush", 32'd1234, 32'hFFFF_FFFE, 1'b0, 5'd9, 64'hFFFF_FFFF_FFFF_F65C);

        // Reset with two operations in flight.
        out_ready = 1'b0;
        idx = 0;
        for (int unsigned c = 0; c < 10 && idx < 2; c++) begin
            in_valid = 1'b1; in_opr1 = $urandom; in_opr2 = $urandom; in_tag = TW'(idx + 1);
            cycle();
            if (obs_acc) idx++;
        end
        in_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check_eq("rst_mid_ov", 64'(obs_ov), 64'd0);
        check_eq("rst_mid_res", obs_res, 64'd0);
        check_eq("rst_mid_ready", 64'(obs_rdy), 64'd1);
        out_ready = 1'b1;
        repeat (6) cycle();

        // Randomized traffic with back-pressure, flushes and occasional resets.
        for (int unsigned c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_opr1     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            in_opr2     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            in_unsigned = $urandom_range(0, 1) != 0;
            in_tag      = TW'($urandom);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 63) == 0);
            reset       = ($urandom_range(0, 255) == 0);
            cycle();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (S + 2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
